// File: rtl/hangman_pkg.sv
// -----------------------------------------------------------------------------
// hangman_pkg
// Shared definitions for the hangman auto-player: game status codes as seen on
// the game's game_output bus, the idle letter code, and the player FSM state
// encoding.
// -----------------------------------------------------------------------------
package hangman_pkg;

  // Status codes reported by the hangman game
  localparam logic [1:0] GAME_PLAY    = 2'd0;
  localparam logic [1:0] GAME_LOSE    = 2'd1;
  localparam logic [1:0] GAME_WIN     = 2'd2;
  localparam logic [1:0] GAME_ILLEGAL = 2'd3;

  // Letter presented to the game whenever no guess is being made (ASCII space)
  localparam logic [6:0] LETTER_IDLE = 7'h20;

  // Player FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRST  = 3'd1,
    ST_GUESS = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/hangman_guess_rom.sv
// -----------------------------------------------------------------------------
// hangman_guess_rom
// Combinational table of guess letters in English letter-frequency order.
// Every letter appears exactly once, so walking the index upward never repeats
// a guess within a game. Unused indices return the idle letter.
//
// Ports:
//   i_idx    in  5  guess index (0 = first guess)
//   o_letter out 7  lowercase ASCII letter for that index, space for 26..31
// -----------------------------------------------------------------------------
module hangman_guess_rom
  import hangman_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic [6:0] o_letter
);

  // Frequency-ordered lookup: e t a o i n s h r d l u c m f w y p v b g k q j x z
  always_comb begin
    o_letter = LETTER_IDLE;
    case (i_idx)
      5'd0:    o_letter = 7'h65; // e
      5'd1:    o_letter = 7'h74; // t
      5'd2:    o_letter = 7'h61; // a
      5'd3:    o_letter = 7'h6F; // o
      5'd4:    o_letter = 7'h69; // i
      5'd5:    o_letter = 7'h6E; // n
      5'd6:    o_letter = 7'h73; // s
      5'd7:    o_letter = 7'h68; // h
      5'd8:    o_letter = 7'h72; // r
      5'd9:    o_letter = 7'h64; // d
      5'd10:   o_letter = 7'h6C; // l
      5'd11:   o_letter = 7'h75; // u
      5'd12:   o_letter = 7'h63; // c
      5'd13:   o_letter = 7'h6D; // m
      5'd14:   o_letter = 7'h66; // f
      5'd15:   o_letter = 7'h77; // w
      5'd16:   o_letter = 7'h79; // y
      5'd17:   o_letter = 7'h70; // p
      5'd18:   o_letter = 7'h76; // v
      5'd19:   o_letter = 7'h62; // b
      5'd20:   o_letter = 7'h67; // g
      5'd21:   o_letter = 7'h6B; // k
      5'd22:   o_letter = 7'h71; // q
      5'd23:   o_letter = 7'h6A; // j
      5'd24:   o_letter = 7'h78; // x
      5'd25:   o_letter = 7'h7A; // z
      default: o_letter = LETTER_IDLE;
    endcase
  end

endmodule

// File: rtl/hangman_player.sv
// -----------------------------------------------------------------------------
// hangman_player
// Automatic guesser for the hangman game. On each accepted start it pulses the
// game's reset for one cycle, then alternates a one-cycle guess with a
// RESP_LAT-cycle wait, sampling game_output at the end of each wait, until the
// game reports WIN/LOSE/illegal or the guess budget is used up.
//
// Parameters:
//   MAX_GUESSES  guess budget per game (1..26)
//   RESP_LAT     cycles between a guess cycle and sampling game_output (>= 1)
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst           in   1  asynchronous active-high reset
//   start         in   1  begin a new game; honoured only in IDLE or DONE
//   game_output   in   2  game status (0 PLAY, 1 LOSE, 2 WIN, 3 illegal)
//   wrong_guesses in   3  game's wrong-guess count, latched on entering DONE
//   letter        out  7  ASCII guess to the game, space when not guessing
//   game_rst      out  1  one-cycle game reset per accepted start
//   busy          out  1  game in progress
//   done          out  1  game finished; held until next start or rst
//   won           out  1  game ended with WIN (valid while done)
//   err           out  1  game ended on an illegal status (valid while done)
//   guess_count   out  5  guesses issued in the current or last game
//   final_wrong   out  3  wrong_guesses latched on entering DONE
// -----------------------------------------------------------------------------
module hangman_player
  import hangman_pkg::*;
#(
  parameter int MAX_GUESSES = 26,
  parameter int RESP_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] game_output,
  input  logic [2:0] wrong_guesses,
  output logic [6:0] letter,
  output logic       game_rst,
  output logic       busy,
  output logic       done,
  output logic       won,
  output logic       err,
  output logic [4:0] guess_count,
  output logic [2:0] final_wrong
);

  // Wide enough to hold RESP_LAT-1; at least one bit.
  localparam int CNT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  state_t             r_state;
  logic [6:0]         r_letter;
  logic               r_game_rst;
  logic               r_busy;
  logic               r_done;
  logic               r_won;
  logic               r_err;
  logic [4:0]         r_guess_count;
  logic [2:0]         r_final_wrong;
  logic [CNT_W-1:0]   r_wait_cnt;

  state_t             w_state_nxt;
  logic [6:0]         w_letter_nxt;
  logic               w_game_rst_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_won_nxt;
  logic               w_err_nxt;
  logic [4:0]         w_guess_count_nxt;
  logic [2:0]         w_final_wrong_nxt;
  logic [CNT_W-1:0]   w_wait_cnt_nxt;
  logic               w_finish;
  logic [6:0]         w_rom_letter;

  // The ROM is addressed by the count of guesses already made, which is the
  // index of the next guess whenever a GUESS state is being entered.
  hangman_guess_rom u_rom (
    .i_idx    (r_guess_count),
    .o_letter (w_rom_letter)
  );

  // State and registered-output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_letter      <= LETTER_IDLE;
      r_game_rst    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_won         <= 1'b0;
      r_err         <= 1'b0;
      r_guess_count <= 5'd0;
      r_final_wrong <= 3'd0;
      r_wait_cnt    <= CNT_W'(0);
    end else begin
      r_state       <= w_state_nxt;
      r_letter      <= w_letter_nxt;
      r_game_rst    <= w_game_rst_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_won         <= w_won_nxt;
      r_err         <= w_err_nxt;
      r_guess_count <= w_guess_count_nxt;
      r_final_wrong <= w_final_wrong_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

  // Next-state and next-output decode. Outputs are computed for the state
  // being entered so that every port comes straight from a flop.
  always_comb begin
    w_state_nxt       = r_state;
    w_letter_nxt      = LETTER_IDLE;
    w_game_rst_nxt    = 1'b0;
    w_busy_nxt        = r_busy;
    w_done_nxt        = r_done;
    w_won_nxt         = r_won;
    w_err_nxt         = r_err;
    w_guess_count_nxt = r_guess_count;
    w_final_wrong_nxt = r_final_wrong;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_finish          = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt       = ST_GRST;
          w_game_rst_nxt    = 1'b1;
          w_busy_nxt        = 1'b1;
          w_done_nxt        = 1'b0;
          w_won_nxt         = 1'b0;
          w_err_nxt         = 1'b0;
          w_guess_count_nxt = 5'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end

      ST_GRST: begin
        w_state_nxt  = ST_GUESS;
        w_letter_nxt = w_rom_letter;
      end

      ST_GUESS: begin
        w_state_nxt       = ST_WAIT;
        w_guess_count_nxt = r_guess_count + 5'd1;
        w_wait_cnt_nxt    = CNT_W'(RESP_LAT - 1);
      end

      ST_WAIT: begin
        if (r_wait_cnt != CNT_W'(0)) begin
          w_wait_cnt_nxt = r_wait_cnt - CNT_W'(1);
        end else begin
          case (game_output)
            GAME_WIN: begin
              w_finish  = 1'b1;
              w_won_nxt = 1'b1;
            end
            GAME_LOSE: begin
              w_finish  = 1'b1;
              w_won_nxt = 1'b0;
            end
            GAME_ILLEGAL: begin
              w_finish  = 1'b1;
              w_won_nxt = 1'b0;
              w_err_nxt = 1'b1;
            end
            default: begin
              // Still in play: stop only when the budget is spent
              if (r_guess_count == 5'(MAX_GUESSES)) begin
                w_finish  = 1'b1;
                w_won_nxt = 1'b0;
              end else begin
                w_state_nxt  = ST_GUESS;
                w_letter_nxt = w_rom_letter;
              end
            end
          endcase
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Common DONE entry from any of the terminating WAIT outcomes
    if (w_finish) begin
      w_state_nxt       = ST_DONE;
      w_busy_nxt        = 1'b0;
      w_done_nxt        = 1'b1;
      w_final_wrong_nxt = wrong_guesses;
    end else begin
      w_final_wrong_nxt = r_final_wrong;
    end
  end

  assign letter      = r_letter;
  assign game_rst    = r_game_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign won         = r_won;
  assign err         = r_err;
  assign guess_count = r_guess_count;
  assign final_wrong = r_final_wrong;

endmodule

// File: tb/tb_hangman_player.sv
// -----------------------------------------------------------------------------
// tb_hangman_player
// Scoreboard bench for hangman_player. Instance 0 uses default parameters and
// plays against a small behavioural game (secret word, 5-wrong loss limit,
// optional illegal-status mode). Instance 1 uses MAX_GUESSES=3, RESP_LAT=2 and
// faces a game that never ends. Expected letters (with their cycle) and
// expected game results are pushed when start is driven and popped when the
// DUT shows a letter or raises done. Cycle numbers: the cycle in which start is
// high is the game's base cycle; game_rst is high in base+1, the i-th guess is
// shown in base+2+i*(1+RESP_LAT), and done rises in base+2+N*(1+RESP_LAT).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hangman_player;
  import hangman_pkg::*;

  localparam logic [6:0] SP = 7'h20;
  localparam int LAT1  = 2;
  localparam int MAXG1 = 3;

  typedef struct {
    logic [6:0] ch;
    int         cyc;
  } let_exp_t;

  typedef struct {
    logic       won;
    logic       err;
    logic [4:0] gc;
    logic [2:0] fw;
    int         done_cyc;
    int         base;
  } res_exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [2];
  logic [6:0] letter_s [2];
  logic       grst_s [2];
  logic       busy_s [2];
  logic       done_s [2];
  logic       won_s [2];
  logic       err_s [2];
  logic [4:0] gc_s [2];
  logic [2:0] fw_s [2];

  // Game model state for instance 0
  logic [1:0] g_out   = 2'd0;
  logic [2:0] g_wrong = 3'd0;
  logic [7:0] g_found = 8'd0;
  string      g_secret = "eat";
  int         g_mode   = 0;     // 0 normal, 1 illegal status on first guess

  // Instance 1 sees a game that never leaves PLAY
  logic [1:0] g2_out   = 2'd0;
  logic [2:0] g2_wrong = 3'd4;

  int cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;

  let_exp_t q_let [$];
  res_exp_t q_res [$];

  string freq = "etaoinshrdlucmfwypvbgkqjxz";

  always #5 clk = ~clk;

  hangman_player u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]),
    .game_output(g_out), .wrong_guesses(g_wrong),
    .letter(letter_s[0]), .game_rst(grst_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .won(won_s[0]), .err(err_s[0]),
    .guess_count(gc_s[0]), .final_wrong(fw_s[0])
  );

  hangman_player #(.MAX_GUESSES(MAXG1), .RESP_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]),
    .game_output(g2_out), .wrong_guesses(g2_wrong),
    .letter(letter_s[1]), .game_rst(grst_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .won(won_s[1]), .err(err_s[1]),
    .guess_count(gc_s[1]), .final_wrong(fw_s[1])
  );

  function automatic logic [7:0] hit_mask(string s, logic [6:0] l);
    logic [7:0] m;
    byte        b;
    m = 8'd0;
    for (int i = 0; i < s.len() && i < 8; i++) begin
      b = s[i];
      if (b[6:0] == l) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [7:0] full_mask(string s);
    return (8'd1 << s.len()) - 8'd1;
  endfunction

  // Behavioural hangman game driven by instance 0
  always @(posedge clk) begin
    if (grst_s[0]) begin
      g_out   <= 2'd0;
      g_wrong <= 3'd0;
      g_found <= 8'd0;
    end else if (g_out == 2'd0 && letter_s[0] != SP) begin
      if (g_mode == 1) begin
        g_out <= 2'd3;
      end else if (hit_mask(g_secret, letter_s[0]) != 8'd0) begin
        g_found <= g_found | hit_mask(g_secret, letter_s[0]);
        if ((g_found | hit_mask(g_secret, letter_s[0])) == full_mask(g_secret))
          g_out <= 2'd2;
      end else begin
        g_wrong <= g_wrong + 3'd1;
        if (g_wrong + 3'd1 == 3'd5) g_out <= 2'd1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected letters and result of one game, replayed from the letter order
  function automatic void predict(string sec, int mode, int maxg, int lat,
                                  int base, logic [2:0] tied_wrong);
    int         wrong;
    int         n;
    logic [7:0] found;
    logic [7:0] m;
    logic       w;
    logic       e;
    bit         fin;
    byte        b;
    res_exp_t   r;
    wrong = 0; n = 0; found = 8'd0; w = 1'b0; e = 1'b0; fin = 1'b0;
    for (int i = 0; i < maxg && !fin; i++) begin
      b = freq[i];
      q_let.push_back('{ch: b[6:0], cyc: base + 2 + i * (1 + lat)});
      n = i + 1;
      if (mode == 1) begin
        e = 1'b1; fin = 1'b1;
      end else if (mode == 0) begin
        m = hit_mask(sec, b[6:0]);
        if (m != 8'd0) begin
          found = found | m;
          if (found == full_mask(sec)) begin w = 1'b1; fin = 1'b1; end
        end else begin
          wrong++;
          if (wrong == 5) fin = 1'b1;
        end
      end
    end
    r.won = w; r.err = e; r.gc = 5'(n);
    r.fw = (mode == 2) ? tied_wrong : 3'(wrong);
    r.done_cyc = base + 2 + n * (1 + lat);
    r.base = base;
    q_res.push_back(r);
  endfunction

  task automatic check_reset(int k);
    check_eq("rst_letter", letter_s[k], SP);
    check_eq("rst_game_rst", grst_s[k], 1'b0);
    check_eq("rst_busy", busy_s[k], 1'b0);
    check_eq("rst_done", done_s[k], 1'b0);
    check_eq("rst_won", won_s[k], 1'b0);
    check_eq("rst_err", err_s[k], 1'b0);
    check_eq("rst_guess_count", gc_s[k], 5'd0);
    check_eq("rst_final_wrong", fw_s[k], 3'd0);
  endtask

  task automatic wait_drained(int limit);
    int n;
    n = 0;
    while (q_res.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", q_res.size(), 0);
    check_eq("letters_left", q_let.size(), 0);
  endtask

  task automatic run_game(int k, string sec, int mode);
    g_secret = sec;
    g_mode   = mode;
    predict(sec, mode, (k == 1) ? MAXG1 : 26, (k == 1) ? LAT1 : 1, cyc, g2_wrong);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    wait_drained(300);
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on letters and on done rising
  bit       prev_done [2];
  int       grst_n [2];
  int       grst_cyc [2];
  initial begin
    let_exp_t le;
    res_exp_t re;
    for (int k = 0; k < 2; k++) begin
      prev_done[k] = 1'b0; grst_n[k] = 0; grst_cyc[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          prev_done[k] = 1'b0;
          grst_n[k]    = 0;
        end else begin
          if (letter_s[k] != SP) begin
            if (q_let.size() == 0) begin
              check_eq("unexpected_letter", letter_s[k], SP);
            end else begin
              le = q_let.pop_front();
              check_eq("letter", letter_s[k], le.ch);
              check_eq("letter_cycle", cyc, le.cyc);
            end
          end
          if (grst_s[k]) begin
            grst_n[k]++;
            grst_cyc[k] = cyc;
            check_eq("busy_in_grst", busy_s[k], 1'b1);
          end
          if (done_s[k] && !prev_done[k]) begin
            if (q_res.size() == 0) begin
              check_eq("unexpected_done", done_s[k], 1'b0);
            end else begin
              re = q_res.pop_front();
              check_eq("won", won_s[k], re.won);
              check_eq("err", err_s[k], re.err);
              check_eq("guess_count", gc_s[k], re.gc);
              check_eq("final_wrong", fw_s[k], re.fw);
              check_eq("done_cycle", cyc, re.done_cyc);
              check_eq("busy_at_done", busy_s[k], 1'b0);
              check_eq("game_rst_pulses", grst_n[k], 1);
              check_eq("game_rst_cycle", grst_cyc[k], re.base + 1);
            end
            grst_n[k] = 0;
          end
          prev_done[k] = done_s[k];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence
  initial begin
    int base;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Win in three guesses
    run_game(0, "eat", 0);
    // Five misses lose the game
    run_game(0, "qj", 0);
    // Budget exhaustion on the MAX_GUESSES=3, RESP_LAT=2 instance
    run_game(1, "", 2);
    // Illegal status on the first sample
    run_game(0, "eat", 1);

    // Reset during the second WAIT, then a clean replay
    g_secret = "eat";
    g_mode   = 0;
    base = cyc;
    predict("eat", 0, 26, 1, base, 3'd0);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    while (cyc < base + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset(0);
    q_let.delete();
    q_res.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_game(0, "eat", 0);

    // start held high: ignored while busy, relaunches from DONE
    base = cyc;
    predict("eat", 0, 26, 1, base, 3'd0);
    predict("eat", 0, 26, 1, base + 8, 3'd0);
    start_s[0] = 1'b1;
    while (cyc < base + 12) @(negedge clk);
    start_s[0] = 1'b0;
    wait_drained(300);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hangman_player.md
Name: hangman_player

Overview:
- Automatic guesser that sits on the other end of the hangman game interface.
- Drives the game's reset and letter inputs, reads back game_output and wrong_guesses, and plays one full game per start pulse.
- Guesses letters in a fixed English-frequency order until the game reports WIN or LOSE, or the guess budget runs out.
- Used as a self-playing stimulus source and as a demo top alongside the game.

Parameters:
- MAX_GUESSES, 26: guess budget per game; legal range 1..26.
- RESP_LAT, 1: cycles the player waits after a guess cycle before sampling game_output; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new game; honoured only in IDLE or DONE.
- game_output  input  2  game status: 0 PLAY, 1 LOSE, 2 WIN, 3 illegal.
- wrong_guesses  input  3  game's wrong-guess count; latched for reporting only.
- letter  output  7  ASCII guess presented to the game; 7'h20 (space) when not guessing.
- game_rst  output  1  drives the game's rst; high for exactly one cycle per start.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  high in DONE; stays high until the next start or rst.
- won  output  1  valid while done; 1 means the game reported WIN.
- err  output  1  valid while done; 1 means game_output was 3 when sampled.
- guess_count  output  5  number of guesses issued in the current or last game.
- final_wrong  output  3  wrong_guesses value latched when DONE is entered.

Behaviour:
- Async reset values:
  - state = IDLE, letter = 7'h20, game_rst = 0.
  - busy, done, won, err = 0.
  - guess_count = 0, final_wrong = 0, wait counter = 0.
- All outputs are registered.
- IDLE/DONE, start sampled high -> GRST:
  - Clears guess_count, won, err and done.
- GRST, one cycle:
  - game_rst = 1, letter = space, busy = 1.
  - Next state is GUESS.
- GUESS, one cycle:
  - letter = rom[guess_count].
  - guess_count increments at the end of the cycle.
  - Next state is WAIT with the wait counter loaded to RESP_LAT-1.
- WAIT:
  - letter = space.
  - While the counter is nonzero, decrement it.
  - When the counter is zero, sample game_output and take the first matching action:
  - 2 -> DONE with won = 1.
  - 1 -> DONE with won = 0.
  - 3 -> DONE with err = 1 and won = 0.
  - 0 with guess_count == MAX_GUESSES -> DONE with won = 0 (budget exhausted).
  - 0 otherwise -> GUESS.
- Entering DONE:
  - busy = 0, done = 1, final_wrong = wrong_guesses as sampled.
  - letter stays space.
- start while busy: ignored, with no effect on state or outputs.
- With RESP_LAT = 1, each guess occupies 2 cycles. done rises 2 + 2N cycles after the start-sampling edge, where N is the guess count.
- Guess ROM order, index 0..25: e t a o i n s h r d l u c m f w y p v b g k q j x z (lowercase ASCII).
  - No letter repeats within a game, so the player never causes a duplicate guess.
- rst mid-game: immediate return to the reset values, game_rst = 0; no game reset is issued until the next start.
- start in DONE restarts cleanly. Back-to-back games need no IDLE cycle.

Decomposition:
- Shared package hangman_pkg holds:
  - game_output codes GAME_PLAY = 2'd0, GAME_LOSE = 2'd1, GAME_WIN = 2'd2.
  - LETTER_IDLE = 7'h20.
  - State encoding for IDLE, GRST, GUESS, WAIT, DONE.
- One sub-module: hangman_guess_rom.
  - Combinational; 5-bit index in, 7-bit ASCII out.
  - Indices 26..31 return space.

Test Plan:
- Bench game model with secret "eat" and a 5-wrong loss limit; pulse start:
  - letter sequence e, t, a with spaces between.
  - done rises 8 cycles after start is sampled; won = 1, guess_count = 3, final_wrong = 0.
- Secret "qj", same 5-wrong loss limit:
  - guesses e, t, a, o, i.
  - LOSE sampled after i; won = 0, err = 0, guess_count = 5, final_wrong = 5.
- MAX_GUESSES = 3 with a model that never ends:
  - done after exactly 3 guesses; won = 0, err = 0, guess_count = 3.
- Model forces game_output = 3 on the first sample:
  - done with err = 1, won = 0, guess_count = 1.
- Assert rst during the second WAIT of the "eat" game:
  - all outputs return to reset values within the same cycle.
  - A later start replays e, t, a from index 0 with a fresh game_rst pulse.
- start held high through the whole "eat" game:
  - exactly one game_rst pulse while busy; the extra start cycles are ignored.
  - After DONE the still-high start launches a second game, and game_rst pulses again.
